logic_gate_unit: RTL

- Parametrised, registered two-input bitwise logic unit: one datapath implements AND, OR, NAND, NOR, XOR, XNOR, NOT and BUF, selected per transaction by an op code.
- Replaces the single-function combinational gate cells; valid/ready on both sides so it drops into streaming datapaths.
- Built-in self-test (BIST) sequencer drives the exhaustive 2-input truth-table sweep through the live datapath and reports pass/fail.

---
 rtl/logic_gate_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered two-input bitwise logic unit (AND/OR/NAND/NOR/
// XOR/XNOR/NOT/BUF) with valid/ready handshakes and a built-in self-test
// sequencer that sweeps the full 2-input truth table through the live datapath.
// Optional build macro LOGIC_GATE_FAULT_INJ_EN adds a fault_inj port that
// corrupts NOR results seen by the self-test compare (never normal traffic).
module logic_gate_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   input  logic             bist_start,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_pass
`ifdef LOGIC_GATE_FAULT_INJ_EN
   ,
   input  logic             fault_inj
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_SWEEP,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             out_valid_q, out_valid_d;
   logic             pass_q, pass_d;
   logic [4:0]       vec_q, vec_d;       // {op, pat} of the next vector to apply
   logic             last_q, last_d;     // vector 31 has been applied
   logic             chk_vld_q, chk_vld_d; // y_q holds a sweep result to compare
   logic [4:0]       chk_v_q, chk_v_d;   // vector that produced y_q
   logic             err_q, err_d;
   logic [WIDTH-1:0] y_chk;
   logic             mismatch;
   logic             xfer;

   // The one datapath shared by traffic and self-test.
   function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
      logic [WIDTH-1:0] r;
      case (f)
         3'd0:    r = x & z;
         3'd1:    r = x | z;
         3'd2:    r = ~(x & z);
         3'd3:    r = ~(x | z);
         3'd4:    r = x ^ z;
         3'd5:    r = ~(x ^ z);
         3'd6:    r = ~x;
         default: r = x;
      endcase
      return r;
   endfunction

   // Golden truth tables, indexed by {a,b}; deliberately not derived from gate_eval.
   function automatic logic tt_bit(input logic [4:0] v);
      logic [3:0] tt;
      case (v[4:2])
         3'd0:    tt = 4'b1000;
         3'd1:    tt = 4'b1110;
         3'd2:    tt = 4'b0111;
         3'd3:    tt = 4'b0001;
         3'd4:    tt = 4'b0110;
         3'd5:    tt = 4'b1001;
         3'd6:    tt = 4'b0011;
         default: tt = 4'b1100;
      endcase
      return tt[v[1:0]];
   endfunction

   assign in_ready  = !rst && (state_q == ST_IDLE) && !bist_start && (!out_valid_q || out_ready);
   assign xfer      = in_valid && in_ready;
   assign y         = y_q;
   assign out_valid = out_valid_q;
   assign bist_busy = (state_q != ST_IDLE);
   assign bist_done = (state_q == ST_DONE);
   assign bist_pass = pass_q;

   // Self-test compare of the previously registered sweep result.
   always_comb begin
      y_chk = y_q;
`ifdef LOGIC_GATE_FAULT_INJ_EN
      if (fault_inj && (chk_v_q[4:2] == 3'd3)) y_chk[0] = ~y_q[0];
`endif
      mismatch = chk_vld_q && (y_chk != {WIDTH{tt_bit(chk_v_q)}});
   end

   // Next-state for the sequencer and the output register.
   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      out_valid_d = out_valid_q;
      pass_d      = pass_q;
      vec_d       = vec_q;
      last_d      = last_q;
      chk_vld_d   = chk_vld_q;
      chk_v_d     = chk_v_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bist_start) begin
               if (out_valid_q) begin
                  state_d = ST_DRAIN;
                  if (out_ready) out_valid_d = 1'b0;
               end else begin
                  state_d   = ST_SWEEP;
                  vec_d     = 5'd0;
                  last_d    = 1'b0;
                  chk_vld_d = 1'b0;
                  err_d     = 1'b0;
                  pass_d    = 1'b0;
               end
            end else if (xfer) begin
               y_d         = gate_eval(op, a, b);
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (!out_valid_q || out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_SWEEP;
               vec_d       = 5'd0;
               last_d      = 1'b0;
               chk_vld_d   = 1'b0;
               err_d       = 1'b0;
               pass_d      = 1'b0;
            end
         end
         ST_SWEEP: begin
            if (mismatch) err_d = 1'b1;
            if (!last_q) begin
               y_d       = gate_eval(vec_q[4:2], {WIDTH{vec_q[1]}}, {WIDTH{vec_q[0]}});
               chk_vld_d = 1'b1;
               chk_v_d   = vec_q;
               if (vec_q == 5'd31) last_d = 1'b1;
               else                vec_d  = vec_q + 5'd1;
            end else begin
               chk_vld_d = 1'b0;
               y_d       = '0;
               pass_d    = !(err_q || mismatch);
               state_d   = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         pass_q      <= 1'b0;
         vec_q       <= 5'd0;
         last_q      <= 1'b0;
         chk_vld_q   <= 1'b0;
         chk_v_q     <= 5'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         pass_q      <= pass_d;
         vec_q       <= vec_d;
         last_q      <= last_d;
         chk_vld_q   <= chk_vld_d;
         chk_v_q     <= chk_v_d;
         err_q       <= err_d;
      end
   end

endmodule
